// File: rtl/comparator_checker.sv
// Exhaustive sweep checker for a WIDTH-bit unsigned magnitude comparator.
// Drives every (a,b) pair, waits SETTLE cycles, then checks the lt/eq/gt flags.
module comparator_checker #(
   parameter int unsigned WIDTH  = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic                 lt_in,
   input  logic                 eq_in,
   input  logic                 gt_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [WIDTH-1:0]     err_a,
   output logic [WIDTH-1:0]     err_b,
   output logic [2:0]           err_flags,
   output logic [2*WIDTH:0]     check_count
);

   localparam int unsigned CW          = 2 * WIDTH + 1;
   localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE_ST,
      CHECK,
      DONE,
      FAIL
   } state_t;

   state_t           r_state, w_state_nx;
   logic [WIDTH-1:0] r_a, w_a_nx;
   logic [WIDTH-1:0] r_b, w_b_nx;
   logic [WIDTH-1:0] r_err_a, w_err_a_nx;
   logic [WIDTH-1:0] r_err_b, w_err_b_nx;
   logic [2:0]       r_err_flags, w_err_flags_nx;
   logic [CW-1:0]    r_count, w_count_nx;
   logic [3:0]       r_settle, w_settle_nx;

   logic [2:0]       w_expected;
   logic [2:0]       w_observed;
   logic             w_match;

   assign w_expected = {r_a < r_b, r_a == r_b, r_a > r_b};
   assign w_observed = {lt_in, eq_in, gt_in};
   // Exact pattern compare also rejects any non-one-hot flag set.
   assign w_match    = (w_observed == w_expected);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_err_a     <= '0;
         r_err_b     <= '0;
         r_err_flags <= '0;
         r_count     <= '0;
         r_settle    <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_a         <= w_a_nx;
         r_b         <= w_b_nx;
         r_err_a     <= w_err_a_nx;
         r_err_b     <= w_err_b_nx;
         r_err_flags <= w_err_flags_nx;
         r_count     <= w_count_nx;
         r_settle    <= w_settle_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_a_nx         = r_a;
      w_b_nx         = r_b;
      w_err_a_nx     = r_err_a;
      w_err_b_nx     = r_err_b;
      w_err_flags_nx = r_err_flags;
      w_count_nx     = r_count;
      w_settle_nx    = r_settle;

      case (r_state)
         IDLE, DONE, FAIL: begin
            if (start) begin
               w_state_nx     = SETTLE_ST;
               w_a_nx         = '0;
               w_b_nx         = '0;
               w_err_a_nx     = '0;
               w_err_b_nx     = '0;
               w_err_flags_nx = '0;
               w_count_nx     = '0;
               w_settle_nx    = SETTLE_LOAD;
            end
         end
         SETTLE_ST: begin
            if (r_settle == 4'd0) begin
               w_state_nx = CHECK;
            end else begin
               w_settle_nx = r_settle - 4'd1;
            end
         end
         CHECK: begin
            if (w_match) begin
               w_count_nx = r_count + CW'(1);
               // b is the inner loop; the sweep ends after the (max,max) pair.
               if (r_b != '1) begin
                  w_b_nx      = r_b + WIDTH'(1);
                  w_settle_nx = SETTLE_LOAD;
                  w_state_nx  = SETTLE_ST;
               end else if (r_a != '1) begin
                  w_b_nx      = '0;
                  w_a_nx      = r_a + WIDTH'(1);
                  w_settle_nx = SETTLE_LOAD;
                  w_state_nx  = SETTLE_ST;
               end else begin
                  w_state_nx = DONE;
               end
            end else begin
               w_err_a_nx     = r_a;
               w_err_b_nx     = r_b;
               w_err_flags_nx = w_observed;
               w_state_nx     = FAIL;
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   assign a_out       = r_a;
   assign b_out       = r_b;
   assign err_a       = r_err_a;
   assign err_b       = r_err_b;
   assign err_flags   = r_err_flags;
   assign check_count = r_count;
   assign busy        = (r_state == SETTLE_ST) || (r_state == CHECK);
   assign done        = (r_state == DONE) || (r_state == FAIL);
   assign pass        = (r_state == DONE);

endmodule

// File: tb/tb_comparator_checker.sv
// Directed bench for comparator_checker: table of comparator fault models plus
// hand-written restart, mid-sweep reset and long-settle sequences.
module tb_comparator_checker;

   localparam int unsigned W = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic           start2 = 1'b0;
   int             mode = 0;

   logic [W-1:0]   a_out, b_out, err_a, err_b;
   logic           lt_in, eq_in, gt_in;
   logic           busy, done, pass;
   logic [2:0]     err_flags;
   logic [2*W:0]   check_count;

   logic [W-1:0]   a2, b2, err_a2, err_b2;
   logic           lt2, eq2, gt2;
   logic           busy2, done2, pass2;
   logic [2:0]     err_flags2;
   logic [2*W:0]   check_count2;

   int             n_cmp = 0;
   int             n_fail = 0;

   always #5 clk = ~clk;

   comparator_checker #(.WIDTH(W), .SETTLE(1)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .a_out(a_out), .b_out(b_out),
      .lt_in(lt_in), .eq_in(eq_in), .gt_in(gt_in),
      .busy(busy), .done(done), .pass(pass),
      .err_a(err_a), .err_b(err_b), .err_flags(err_flags),
      .check_count(check_count)
   );

   comparator_checker #(.WIDTH(W), .SETTLE(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start2),
      .a_out(a2), .b_out(b2),
      .lt_in(lt2), .eq_in(eq2), .gt_in(gt2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_a(err_a2), .err_b(err_b2), .err_flags(err_flags2),
      .check_count(check_count2)
   );

   // Comparator models: 0 correct, 1 gt stuck low, 2 lt+eq on equal, 3 lt/gt swapped
   always_comb begin
      lt_in = (a_out < b_out);
      eq_in = (a_out == b_out);
      gt_in = (a_out > b_out);
      case (mode)
         1: gt_in = 1'b0;
         2: if (a_out == b_out) lt_in = 1'b1;
         3: begin
            lt_in = (a_out > b_out);
            gt_in = (a_out < b_out);
         end
         default: ;
      endcase
   end

   always_comb begin
      lt2 = (a2 < b2);
      eq2 = (a2 == b2);
      gt2 = (a2 > b2);
   end

   typedef struct {
      int mode;
      int cycles;
      int pass;
      int a;
      int b;
      int ea;
      int eb;
      int flags;
      int count;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the start edge until done; poke>=0 re-pulses start mid-sweep.
   task automatic run_sweep(input int poke, output int n);
      n = 0;
      while (!done && n < 400) begin
         if (n == poke) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
      end
   endtask

   initial begin
      int n;
      int run;
      int changes;
      logic [2*W-1:0] prev;

      vecs[0] = '{mode:0, cycles:32, pass:1, a:3, b:3, ea:0, eb:0, flags:0, count:16};
      vecs[1] = '{mode:1, cycles:10, pass:0, a:1, b:0, ea:1, eb:0, flags:0, count:4};
      vecs[2] = '{mode:2, cycles:2,  pass:0, a:0, b:0, ea:0, eb:0, flags:6, count:0};
      vecs[3] = '{mode:3, cycles:4,  pass:0, a:0, b:1, ea:0, eb:1, flags:1, count:1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {busy, done, pass, a_out, b_out, err_a, err_b, err_flags, check_count}, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_wait", {busy, done}, '0);

      for (int i = 0; i < 4; i++) begin
         mode = vecs[i].mode;
         do_start();
         check($sformatf("v%0d_busy_after_start", i), {busy, done, check_count}, {1'b1, 1'b0, 5'd0});
         run_sweep(-1, n);
         check($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_done_busy", i), {done, busy}, 2'b10);
         check($sformatf("v%0d_pass", i), pass, vecs[i].pass);
         check($sformatf("v%0d_a", i), a_out, vecs[i].a);
         check($sformatf("v%0d_b", i), b_out, vecs[i].b);
         check($sformatf("v%0d_err_a", i), err_a, vecs[i].ea);
         check($sformatf("v%0d_err_b", i), err_b, vecs[i].eb);
         check($sformatf("v%0d_err_flags", i), err_flags, vecs[i].flags);
         check($sformatf("v%0d_count", i), check_count, vecs[i].count);
      end

      // start while busy is ignored
      mode = 0;
      do_start();
      run_sweep(10, n);
      check("ignore_start_cycles", n, 32);
      check("ignore_start_pass", {pass, check_count}, {1'b1, 5'd16});

      // restart after done clears results on the start edge
      do_start();
      check("restart_clear", {busy, done, pass, check_count, a_out, b_out}, {1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0});
      run_sweep(-1, n);
      check("restart_cycles", n, 32);
      check("restart_pass", {pass, check_count}, {1'b1, 5'd16});

      // asynchronous reset mid-sweep
      do_start();
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset",
            {busy, done, pass, a_out, b_out, err_a, err_b, err_flags, check_count}, '0);
      @(negedge clk);
      reset = 1'b0;
      do_start();
      run_sweep(-1, n);
      check("post_reset_cycles", n, 32);
      check("post_reset_pass", {pass, check_count}, {1'b1, 5'd16});

      // SETTLE=3 instance: 64-cycle sweep, each pair held for 4 cycles
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      n = 0;
      run = 1;
      changes = 0;
      prev = {a2, b2};
      while (!done2 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (!done2) begin
            if ({a2, b2} != prev) begin
               changes++;
               check($sformatf("s3_hold_%0d", changes), run, 4);
               run = 1;
               prev = {a2, b2};
            end else begin
               run++;
            end
         end
      end
      check("s3_cycles", n, 64);
      check("s3_changes", changes, 15);
      check("s3_result", {pass2, check_count2, a2, b2}, {1'b1, 5'd16, 2'd3, 2'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/comparator_checker.md
COMPARATOR_CHECKER -- requirements
Module: comparator_checker

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the operand width driven to the comparator under test.
REQ-002 Parameter SETTLE, default 1, SHALL set the settle cycles per operand pair; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a sweep; it is sampled only in IDLE, DONE or FAIL.
REQ-006 a_out  output  WIDTH  SHALL be operand a driven to the comparator.
REQ-007 b_out  output  WIDTH  SHALL be operand b driven to the comparator.
REQ-008 lt_in, eq_in, gt_in  input  1 each  SHALL be the comparator status flags.
REQ-009 busy  output  1  SHALL be high while a sweep is in progress.
REQ-010 done  output  1  SHALL be high when the sweep has ended, whether passed or failed.
REQ-011 pass  output  1  SHALL be high only when done is high and all pairs matched.
REQ-012 err_a, err_b  output  WIDTH each  SHALL capture the operands of the first mismatch.
REQ-013 err_flags  output  3  SHALL capture {lt_in,eq_in,gt_in} at the first mismatch.
REQ-014 check_count  output  2*WIDTH+1  SHALL count the pairs that passed in the current sweep.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, CHECK, DONE and FAIL.
REQ-016 A start edge in IDLE/DONE/FAIL SHALL do all of the following:
- set a_out=0 and b_out=0
- clear done, pass, err_* and check_count
- load the settle counter with SETTLE-1
- enter SETTLE with busy=1
REQ-017 In SETTLE, on each edge, the FSM SHALL go to CHECK if the counter is 0, else decrement the counter; SETTLE therefore lasts exactly SETTLE cycles.
REQ-018 CHECK SHALL last one cycle; at its edge {lt_in,eq_in,gt_in} SHALL equal exactly {a_out<b_out, a_out==b_out, a_out>b_out}, with the compare unsigned.
REQ-019 Any non-one-hot or wrong flag pattern SHALL be a mismatch.
REQ-020 On a match at the CHECK edge, check_count SHALL increment, with b_out as the inner loop:
- if b_out is not all-ones: b_out increments
- else if a_out is not all-ones: b_out wraps to 0 and a_out increments
- in both cases above: reload the settle counter and return to SETTLE
- if both are all-ones: enter DONE with done=1, pass=1 and busy=0
REQ-021 On a mismatch at the CHECK edge, the block SHALL:
- load err_a=a_out, err_b=b_out and err_flags with the observed flags
- enter FAIL with done=1, pass=0 and busy=0
- leave check_count unchanged
REQ-022 In DONE/FAIL, a_out, b_out, err_* and check_count SHALL hold until the next start or reset.
REQ-023 Start while busy SHALL be ignored.
REQ-024 Sweep length SHALL be 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to the edge that sets done.
REQ-025 Operands SHALL change only on the edge leaving CHECK or on the start edge; they SHALL stay stable throughout SETTLE and CHECK.

Reset
REQ-026 While reset is high, the block SHALL force IDLE, with a_out=0, b_out=0, busy=0, done=0, pass=0, err_a=0, err_b=0, err_flags=0, check_count=0 and settle counter=0.
REQ-027 Reset asserted mid-sweep SHALL abort it immediately with no partial result retained.
REQ-028 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Correct comparator model, WIDTH=2, SETTLE=1, one-cycle start pulse -> busy high for 32 cycles, then done=1, pass=1, check_count=16.
- Model with gt stuck at 0 -> FAIL at a=1,b=0 with err_a=1, err_b=0, err_flags=3'b000, check_count=4, pass=0, done=1.
- Model driving lt=1 and eq=1 when a==b -> FAIL at the first CHECK with err_a=0, err_b=0, err_flags=3'b110, check_count=0.
- Start pulsed again at cycle 10 of a sweep -> ignored, sweep completes at cycle 32; start pulsed after done -> done/pass clear on that edge and a full 32-cycle sweep repeats.
- Reset asserted at cycle 10 of a sweep -> all outputs 0 and IDLE asynchronously; a following start yields pass=1, check_count=16.
- SETTLE=3, WIDTH=2 with correct model -> done after 64 cycles, each operand pair stable for 4 cycles.
